voice_slot_arbiter: RTL
=======================

Name: voice_slot_arbiter

Overview:
- Shares the synth's fixed pool of voice slots between two note-event requesters: the PS/2-USB keyboard path and the song sequencer.
- Produces the packed 8-bit-per-slot keycode word consumed by the I2S tone generator in place of raw keycodes.
- Round-robin arbitration between requesters; serial slot scan per event; LRU voice stealing when the pool is full.

Parameters:
NUM_VOICES, 4, number of voice slots; voice_word width = 8*NUM_VOICES
AGE_W, 4, width of per-slot LRU age counter (saturating)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
kb_valid  in  1  keyboard event valid
kb_ready  out  1  keyboard event accepted when kb_valid&kb_ready
kb_on  in  1  1=note-on, 0=note-off
kb_code  in  8  keyboard keycode
sq_valid  in  1  sequencer event valid
sq_ready  out  1  sequencer handshake ready
sq_on  in  1  1=note-on, 0=note-off
sq_code  in  8  sequencer keycode
voice_word  out  8*NUM_VOICES  slot i keycode at [8i+7:8i]; 0x00 = slot free
active_mask  out  NUM_VOICES  bit i = slot i non-zero
steal_pulse  out  1  one-cycle pulse when an occupied slot is overwritten
busy  out  1  high whenever FSM not IDLE

Behaviour:
- Reset: voice_word=0, active_mask=0, all ages=0, kb_ready=sq_ready=0 during reset, steal_pulse=0, busy=0, FSM=IDLE, last_grant=SQ (so first tie goes to KB).
- FSM IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE: kb_ready=sq_ready=1 only in IDLE, combinationally gated by arbitration: only one valid requester -> its ready high, other low; both valid -> grant the one not in last_grant, other ready low. Handshake at cycle T latches {on,code}, updates last_grant, enters SCAN.
- SCAN: cycles T+1..T+NUM_VOICES, index 0..NUM_VOICES-1, one slot per cycle. Records: first slot matching code, lowest-index free slot, slot with maximum age (ties -> lowest index).
- COMMIT at T+NUM_VOICES+1; updated voice_word/active_mask visible from T+NUM_VOICES+2; then IDLE, next handshake possible that same cycle.
- Note-on, code present: retrigger; that slot age=0, other ages unchanged, no steal.
- Note-on, no match, free slot exists: write code to lowest free slot, age=0; every other occupied slot age+1 saturating at 2^AGE_W-1.
- Note-on, pool full: overwrite max-age slot, age=0, others age+1 saturating, steal_pulse=1 during COMMIT cycle only.
- Note-off, match: slot cleared to 0x00, age=0. No match: no change.
- code==0x00 (either on/off): event consumed, no slot change, still takes full latency.
- Events arriving while busy are held by requester (ready=0); no loss, no reorder per requester.
- RESET mid-SCAN/COMMIT: latched event discarded, all state to reset values immediately.

Optional Feature:
- VOICE_STEAL_EN defined: full-pool note-on steals LRU slot as above.
- Undefined: full-pool note-on dropped, no slot/age change, steal_pulse tied 0; event still consumed with normal latency.

Test Plan:
- Reset, then kb note-on 0x04 -> voice_word=0x00000004 at cycle T+6 (NUM_VOICES=4), active_mask=0001, busy high T+1..T+5.
- kb on 0x04, 0x16, 0x07, 0x09, then sq on 0x0a -> slot0 (0x04, oldest) replaced: voice_word=0x0907160a, steal_pulse one cycle; without VOICE_STEAL_EN word stays 0x09071604.
- kb_valid and sq_valid both high in IDLE after reset, codes 0x04/0x0b -> kb granted first, sq second; final voice_word=0x00000b04.
- Slots {0x04,0x16}, kb note-off 0x04 -> voice_word=0x00001600, active_mask=0010; note-off 0x0d -> no change.
- Note-on 0x07 while 0x07 held -> no new slot, age of its slot 0, steal_pulse stays 0.
- Assert RESET during SCAN of note-on 0x04 -> voice_word stays 0, FSM IDLE, busy=0 the cycle after deassertion.

Source files
------------

// File: rtl/voice_slot_arbiter.sv
// voice_slot_arbiter: shares NUM_VOICES voice slots between the keyboard and
// sequencer note-event streams. Requesters are served round-robin. Each event
// is handled by a serial slot scan followed by a single commit cycle.
// Optional build macro VOICE_STEAL_EN: when it is defined, a note-on that
// arrives with every slot occupied takes over the least-recently-used slot.
// When it is not defined, that note-on is dropped.
module voice_slot_arbiter #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    kb_valid,
  output logic                    kb_ready,
  input  logic                    kb_on,
  input  logic [7:0]              kb_code,
  input  logic                    sq_valid,
  output logic                    sq_ready,
  input  logic                    sq_on,
  input  logic [7:0]              sq_code,
  output logic [8*NUM_VOICES-1:0] voice_word,
  output logic [NUM_VOICES-1:0]   active_mask,
  output logic                    steal_pulse,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [7:0]        slot_code [NUM_VOICES];
  logic [AGE_W-1:0]  age       [NUM_VOICES];
  logic              last_grant_sq;
  logic              ev_on;
  logic [7:0]        ev_code;
  logic [IDX_W-1:0]  idx;
  logic              match_found, free_found;
  logic [IDX_W-1:0]  match_idx, free_idx, max_idx;
  logic [AGE_W-1:0]  max_age;

  logic              hs_kb, hs_sq;
  logic              alloc, retrig, release_slot;
  logic [IDX_W-1:0]  alloc_idx;

  // Next-state, arbitration (ready/grant) and commit decode
  always_comb begin
    state_nxt    = state;
    kb_ready     = 1'b0;
    sq_ready     = 1'b0;
    hs_kb        = 1'b0;
    hs_sq        = 1'b0;
    alloc        = 1'b0;
    retrig       = 1'b0;
    release_slot = 1'b0;
    alloc_idx    = free_found ? free_idx : max_idx;
    steal_pulse  = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (!RESET) begin
          if (kb_valid && (!sq_valid || last_grant_sq))
            kb_ready = 1'b1;
          else if (sq_valid)
            sq_ready = 1'b1;
        end
        hs_kb = kb_valid && kb_ready;
        hs_sq = sq_valid && sq_ready;
        if (hs_kb || hs_sq)
          state_nxt = SCAN;
      end
      SCAN: begin
        if (idx == LAST_IDX)
          state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (ev_code != 8'h00) begin
          if (ev_on) begin
            retrig = match_found;
`ifdef VOICE_STEAL_EN
            alloc       = !match_found;
            steal_pulse = !match_found && !free_found;
`else
            alloc       = !match_found && free_found;
            steal_pulse = 1'b0;
`endif
          end else begin
            release_slot = match_found;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Event latch, slot scan bookkeeping and slot/age update at commit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant_sq <= 1'b1;
      ev_on         <= 1'b0;
      ev_code       <= '0;
      idx           <= '0;
      match_found   <= 1'b0;
      free_found    <= 1'b0;
      match_idx     <= '0;
      free_idx      <= '0;
      max_idx       <= '0;
      max_age       <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        slot_code[i] <= '0;
        age[i]       <= '0;
      end
    end else begin
      if (hs_kb || hs_sq) begin
        ev_on         <= hs_kb ? kb_on : sq_on;
        ev_code       <= hs_kb ? kb_code : sq_code;
        last_grant_sq <= hs_sq;
        idx           <= '0;
        match_found   <= 1'b0;
        free_found    <= 1'b0;
      end
      if (state == SCAN) begin
        if (!match_found && slot_code[idx] == ev_code) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!free_found && slot_code[idx] == 8'h00) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        // strict '>' keeps the lowest index on equal ages
        if (idx == '0 || age[idx] > max_age) begin
          max_idx <= idx;
          max_age <= age[idx];
        end
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (alloc) begin
          if (IDX_W'(i) == alloc_idx) begin
            slot_code[i] <= ev_code;
            age[i]       <= '0;
          end else if (slot_code[i] != 8'h00 && age[i] != '1) begin
            age[i] <= age[i] + 1'b1;
          end
        end
        if (retrig && IDX_W'(i) == match_idx)
          age[i] <= '0;
        if (release_slot && IDX_W'(i) == match_idx) begin
          slot_code[i] <= '0;
          age[i]       <= '0;
        end
      end
    end
  end

  // Pack slot codes into the tone-generator word and derive occupancy
  always_comb begin
    voice_word  = '0;
    active_mask = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_word[8*i +: 8] = slot_code[i];
      active_mask[i]       = (slot_code[i] != 8'h00);
    end
  end

endmodule
